// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every KxK window of a valid convolution for each filter,
// streaming tap reads to the MAC datapath and issuing one output write per window result.
module conv_window_sequencer #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int K = 3,
   parameter int NUM_FILTERS = 4,
   parameter int ADDR_W = 16,
   localparam int FW = NUM_FILTERS > 1 ? $clog2(NUM_FILTERS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mac_ready,
   input  logic              res_valid,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              tap_first,
   output logic              tap_last,
   output logic [FW-1:0]     filt_idx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              err
);
   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_H = IMG_H - K + 1;
   localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
   localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1;
   localparam int KW = K > 1 ? $clog2(K) : 1;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [FW-1:0] filt_q, filt_d;
   logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
   logic err_q, err_d;
   logic kc_end, kr_end, col_end, row_end, filt_end;
   assign kc_end   = kc_q == KW'(K - 1);
   assign kr_end   = kr_q == KW'(K - 1);
   assign col_end  = col_q == CW'(OUT_W - 1);
   assign row_end  = row_q == RW'(OUT_H - 1);
   assign filt_end = filt_q == FW'(NUM_FILTERS - 1);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         filt_q  <= '0;
         kc_q    <= '0;
         kr_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         filt_q  <= filt_d;
         kc_q    <= kc_d;
         kr_q    <= kr_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      filt_d  = filt_q;
      kc_d    = kc_q;
      kr_d    = kr_q;
      // stray results outside WAIT and restarts while busy are flagged but otherwise ignored
      err_d   = err_q | (res_valid && state_q != WAIT) | (start && state_q != IDLE);
      case (state_q)
         IDLE: if (start) begin
            state_d = FETCH;
            col_d   = '0;
            row_d   = '0;
            filt_d  = '0;
            kc_d    = '0;
            kr_d    = '0;
         end
         FETCH: if (mac_ready) begin
            kc_d    = kc_end ? '0 : kc_q + 1'b1;
            kr_d    = kc_end ? (kr_end ? '0 : kr_q + 1'b1) : kr_q;
            state_d = (kc_end && kr_end) ? WAIT : FETCH;
         end
         WAIT: state_d = res_valid ? WRITE : WAIT;
         WRITE: begin
            col_d   = col_end ? '0 : col_q + 1'b1;
            row_d   = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            filt_d  = (col_end && row_end) ? (filt_end ? '0 : filt_q + 1'b1) : filt_q;
            state_d = (col_end && row_end && filt_end) ? DONE : FETCH;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign rd_en     = state_q == FETCH && mac_ready;
   assign tap_first = rd_en && kc_q == '0 && kr_q == '0;
   assign tap_last  = rd_en && kc_end && kr_end;
   assign wr_en     = state_q == WRITE;
   assign filt_idx  = filt_q;
   assign err       = err_q;
   assign rd_addr   = ADDR_W'((32'(row_q) + 32'(kr_q)) * 32'(IMG_W) + 32'(col_q) + 32'(kc_q));
   assign wr_addr   = ADDR_W'(32'(filt_q) * 32'(OUT_W * OUT_H) + 32'(row_q) * 32'(OUT_W) + 32'(col_q));
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench; the reference pass is an ordered list of
// read/write/done events built from the window-walk arithmetic, popped as the DUT strobes.
module tb_conv_window_sequencer;
   localparam int IW = 5, IH = 5, KK = 3, NF = 2, AW = 16;
   localparam int OW = IW - KK + 1, OH = IH - KK + 1, NWIN = OW * OH * NF;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, mac_ready = 1'b1;
   logic rv_resp = 1'b0, rv_inj = 1'b0, res_valid;
   logic busy, done, rd_en, tap_first, tap_last, wr_en, err;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [0:0] filt_idx;
   assign res_valid = rv_resp | rv_inj;
   conv_window_sequencer #(.IMG_W(IW), .IMG_H(IH), .K(KK), .NUM_FILTERS(NF), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .mac_ready(mac_ready), .res_valid(res_valid),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .tap_first(tap_first),
      .tap_last(tap_last), .filt_idx(filt_idx), .wr_en(wr_en), .wr_addr(wr_addr), .err(err)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {int kind; int addr; bit first; bit last; int filt;} ev_t;
   ev_t exp_q[$];
   ev_t e;
   int checks = 0, errors = 0;
   int extra = 0, slow_win = -1, rand_delay = 0, wcnt = 0, rdel = 0;
   int first_cyc = -1, start_cyc = 0, rv_cyc = -100;
   bit pass_done = 1'b0, done_prev = 1'b0;
   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endfunction
   task automatic push_pass();
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
               for (int kr = 0; kr < KK; kr++)
                  for (int kc = 0; kc < KK; kc++)
                     exp_q.push_back('{0, (r + kr) * IW + c + kc, kr == 0 && kc == 0, kr == KK - 1 && kc == KK - 1, f});
               exp_q.push_back('{1, f * OW * OH + r * OW + c, 1'b0, 1'b0, f});
            end
      exp_q.push_back('{2, 0, 1'b0, 1'b0, 0});
   endtask
   task automatic start_pass();
      push_pass();
      extra = 0;
      wcnt = 0;
      first_cyc = -1;
      pass_done = 1'b0;
      @(posedge clk);
      #1 start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(int exp_err);
      for (int i = 0; i < 4000 && !pass_done; i++) @(negedge clk);
      chk("pass_timeout", int'(pass_done), 1);
      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("err_after_pass", int'(err), exp_err);
      exp_q.delete();
   endtask
   task automatic wait_ev(int n, bit firsts);
      int seen = 0;
      for (int i = 0; i < 4000 && seen < n; i++) begin
         @(negedge clk);
         if (rd_en && (!firsts || tap_first)) seen++;
      end
      chk("wait_ev_timeout", seen, n);
   endtask
   task automatic check_zero();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_tap_first", int'(tap_first), 0);
      chk("rst_tap_last", int'(tap_last), 0);
      chk("rst_filt_idx", int'(filt_idx), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_err", int'(err), 0);
   endtask
   task automatic apply_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 check_zero();
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask
   // result responder: answers each window's last tap, optionally late
   initial forever begin
      @(negedge clk);
      if (rd_en && tap_last) begin
         rdel = (wcnt == slow_win) ? 7 : (rand_delay != 0 ? int'($urandom_range(0, 3)) : 0);
         wcnt++;
         extra += rdel;
         @(posedge clk);
         repeat (rdel) @(posedge clk);
         #1 rv_resp = 1'b1;
         @(posedge clk);
         #1 rv_resp = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (res_valid) rv_cyc = cyc;
      if (done_prev) chk("busy_after_done", int'(busy), 0);
      done_prev = done;
      chk("one_strobe", int'(rd_en) + int'(wr_en) + int'(done) <= 1 ? 1 : 0, 1);
      chk("tap_qual", int'((tap_first | tap_last) & ~rd_en), 0);
      if (!mac_ready && busy && exp_q.size() > 0 && exp_q[0].kind == 0) begin
         chk("stall_rd_en", int'(rd_en), 0);
         chk("stall_addr", int'(rd_addr), exp_q[0].addr);
      end
      if (rd_en | wr_en | done) begin
         if (exp_q.size() == 0) chk("unexpected_event", int'({rd_en, wr_en, done}), 0);
         else begin
            e = exp_q.pop_front();
            chk("event_kind", rd_en ? 0 : (wr_en ? 1 : 2), e.kind);
            if (e.kind == 0) begin
               chk("rd_addr", int'(rd_addr), e.addr);
               chk("tap_first", int'(tap_first), int'(e.first));
               chk("tap_last", int'(tap_last), int'(e.last));
               chk("rd_filt", int'(filt_idx), e.filt);
               if (first_cyc < 0) begin
                  first_cyc = cyc;
                  chk("first_rd_latency", cyc - start_cyc, 1);
                  chk("busy_in_pass", int'(busy), 1);
               end
            end else if (e.kind == 1) begin
               chk("wr_addr", int'(wr_addr), e.addr);
               chk("wr_filt", int'(filt_idx), e.filt);
               chk("wr_after_res", cyc - rv_cyc, 1);
            end else begin
               chk("pass_length", cyc - first_cyc, NWIN * (KK * KK + 2) + extra);
               pass_done = 1'b1;
            end
         end
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #1 check_zero();
      reset = 1'b1;
      start_pass();
      wait_done(0);
      start_pass();
      wait_ev(9 + 4, 1'b0);
      @(posedge clk);
      #1 mac_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1 mac_ready = 1'b1;
      extra += 4;
      wait_done(0);
      slow_win = 3;
      start_pass();
      wait_done(0);
      slow_win = -1;
      rand_delay = 1;
      repeat (2) begin
         start_pass();
         wait_done(0);
      end
      rand_delay = 0;
      start_pass();
      wait_ev(int'($urandom_range(1, 6)), 1'b1);
      chk("err_before_start", int'(err), 0);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("err_start_busy", int'(err), 1);
      wait_done(1);
      apply_reset();
      start_pass();
      wait_ev(int'($urandom_range(1, 6)), 1'b1);
      chk("err_before_res", int'(err), 0);
      @(posedge clk);
      #1 rv_inj = 1'b1;
      @(posedge clk);
      #1 rv_inj = 1'b0;
      chk("err_res_fetch", int'(err), 1);
      wait_done(1);
      start_pass();
      wait_ev(4 * KK * KK + 3, 1'b0);
      apply_reset();
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", int'(pass_done), 0);
      start_pass();
      wait_done(0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Controller that sequences the convolution datapath inside the feature-extraction pipeline over one image. On `start` it walks every valid K×K window position for each filter. For each window it issues the K×K pixel reads to the MAC datapath, waits for the datapath result, then issues one output-feature-map write. It owns all address generation, so the datapath only sees a tap stream and returns one result per window.

## Interface
Parameters:
- `IMG_W`, default 32: input image width in pixels.
- `IMG_H`, default 32: input image height in pixels.
- `K`, default 3: square kernel size. Must satisfy K ≤ IMG_W and K ≤ IMG_H.
- `NUM_FILTERS`, default 4: number of filters applied per pass.
- `ADDR_W`, default 16: width of the read and write addresses.

Derived values: OUT_W = IMG_W−K+1 and OUT_H = IMG_H−K+1 (valid convolution, stride 1, no padding).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin one pass. Sampled only in IDLE.
- `mac_ready`, in, 1: datapath can accept a tap this cycle.
- `res_valid`, in, 1: datapath window result is available.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse at the end of a pass.
- `rd_en`, out, 1: tap read strobe.
- `rd_addr`, out, ADDR_W: pixel address (row+kr)*IMG_W + (col+kc).
- `tap_first`, out, 1: qualifies `rd_en` for tap (0,0).
- `tap_last`, out, 1: qualifies `rd_en` for tap (K−1,K−1).
- `filt_idx`, out, clog2(NUM_FILTERS): current filter; drives the datapath weight select.
- `wr_en`, out, 1: output write strobe.
- `wr_addr`, out, ADDR_W: filt*OUT_W*OUT_H + row*OUT_W + col.
- `err`, out, 1: sticky protocol error flag.

## Operation
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
- Counters:
  - `col`: 0..OUT_W−1
  - `row`: 0..OUT_H−1
  - `filt`: 0..NUM_FILTERS−1
  - `kc`: 0..K−1
  - `kr`: 0..K−1
- IDLE: when `start`=1, clear all counters and go to FETCH.
- FETCH:
  - Each cycle with `mac_ready`=1: assert `rd_en`, then advance `kc`. When `kc` wraps, advance `kr`.
  - On the tap with kr=kc=K−1: assert `tap_last` and go to WAIT.
  - With `mac_ready`=0: `rd_en`=0 and all counters hold (stall).
- WAIT: hold until `res_valid`=1, then go to WRITE. There is no timeout.
- WRITE: assert `wr_en` for exactly one cycle with the current window's `wr_addr`. In the same cycle, advance the window position:
  - `col`++.
  - On `col` wrap: `row`++.
  - On `row` wrap: `filt`++.
  - After the last window of the last filter, go to DONE. Otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Protocol errors set `err` (cleared only by reset):
  - `res_valid`=1 in any state other than WAIT. The pulse is otherwise ignored.
  - `start`=1 while `busy`=1. The start is otherwise ignored.
- Addresses are computed combinationally from the registered counters. They are zero-extended or truncated to ADDR_W; the integrator guarantees they fit.
- Reset:
  - Every output is 0 in reset: `busy`, `done`, `rd_en`, `rd_addr`, `tap_first`, `tap_last`, `filt_idx`, `wr_en`, `wr_addr`, `err`.
  - The state goes to IDLE.
  - Reset asserted mid-pass aborts immediately. No `wr_en` or `done` follows.

## Timing
- `start` sampled high in IDLE at cycle t: the first `rd_en` (with `tap_first`) is at t+1 if `mac_ready`=1.
- Unstalled window length is K*K + Wn + 1 cycles, where Wn ≥ 1 is the number of WAIT cycles up to and including the `res_valid` cycle.
- `wr_en` is asserted the cycle after `res_valid` is sampled.
- `done` follows the final WRITE cycle by one cycle.
- `busy` rises at t+1 and falls the cycle after `done`.
- `rd_en`, `wr_en` and `done` are never high in the same cycle.
- `tap_first` and `tap_last` are only ever high together with `rd_en`.

## Test plan
All scenarios use IMG_W=IMG_H=5, K=3, NUM_FILTERS=2, `mac_ready`=1 unless stated, and `res_valid` pulsed in the first WAIT cycle.
- Full pass: `start` → 18 `wr_en` pulses with `wr_addr` 0..17 in order. `done` arrives exactly 198 cycles after the first `rd_en`. `busy` is low after `done`.
- Address pattern: first window reads 0,1,2,5,6,7,10,11,12. Last window of each filter reads 12,13,14,17,18,19,22,23,24. `filt_idx` is 0 for the first 9 writes and 1 for the rest.
- Stall: hold `mac_ready`=0 for 4 cycles mid-window → no `rd_en` and no address change during the stall; the tap sequence resumes unchanged and the pass lengthens by 4 cycles.
- Slow result: `res_valid` delayed 7 cycles in WAIT → `wr_en` comes exactly 1 cycle after `res_valid`; no extra reads are issued.
- Protocol errors: `res_valid` pulsed during FETCH and `start` pulsed mid-pass → `err`=1; sequence and write count are unaffected.
- Reset mid-pass: drive `reset`=0 during window 5 → all outputs 0 on the next edge. After release, a new `start` reproduces the full-pass results.
